seq_multiplier: RTL

Parametrised shift-add multiplier with an integrated control FSM, product register, and start/ready handshake. It generalises the fixed 32-bit Product-register datapath to any operand width and adds optional two's-complement mode. It sits beside the ALU in the execution path. The issuing block presents operands with `Start` and waits for `Ready`.

---
 rtl/mul_pkg.sv | 23 ++
 rtl/mul_alu.sv | 22 ++
 rtl/seq_multiplier.sv | 111 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg : shared state encoding and sizing helper for seq_multiplier
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter must hold values 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_alu.sv
// ---------------------------------------------------------------------------
// mul_alu : WIDTH-bit adder returning the full carry-out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_alu
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier : shift-add multiplier with start/ready handshake, opt. signed
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Signed_mode,
  input  logic [WIDTH-1:0]     Multiplicand_in,
  input  logic [WIDTH-1:0]     Multiplier_in,
  output logic                 Busy,
  output logic                 Ready,
  output logic [2*WIDTH-1:0]   Product_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W   = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W  = 1;
  localparam logic [CW-1:0]      CNT_ONE = 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] work;       // {hi, lo}
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [2*WIDTH-1:0] product;

  logic               signed_eff;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   alu_sum;
  logic               alu_carry;
  logic [WIDTH:0]     hi_next;
  logic [2*WIDTH-1:0] work_shift;
  logic               last_iter;

  assign signed_eff = Signed_mode & SIGNED_EN;
  assign a_neg      = signed_eff & Multiplicand_in[WIDTH-1];
  assign b_neg      = signed_eff & Multiplier_in[WIDTH-1];
  assign a_mag      = a_neg ? (~Multiplicand_in + ONE_W) : Multiplicand_in;
  assign b_mag      = b_neg ? (~Multiplier_in + ONE_W) : Multiplier_in;

  mul_alu #(.WIDTH(WIDTH)) u_alu (
    .a     (work[2*WIDTH-1:WIDTH]),
    .b     (mcand),
    .sum   (alu_sum),
    .carry (alu_carry)
  );

  // The carry bit of {carry,hi,lo} only lives for one cycle: it is always
  // shifted straight into hi[MSB], so it is kept combinational here.
  assign hi_next    = work[0] ? {alu_carry, alu_sum} : {1'b0, work[2*WIDTH-1:WIDTH]};
  assign work_shift = {hi_next, work[WIDTH-1:1]};
  assign last_iter  = (cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (Start) state_next = RUN;
      RUN:        if (last_iter) state_next = SIGN;
      SIGN:       state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      mcand   <= '0;
      work    <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            mcand <= a_mag;
            work  <= {{WIDTH{1'b0}}, b_mag};
            neg   <= a_neg ^ b_neg;
            cnt   <= '0;
          end
        end
        RUN: begin
          work <= work_shift;
          cnt  <= cnt + CNT_ONE;
        end
        SIGN: product <= neg ? (~work + ONE_2W) : work;
        default: ;
      endcase
    end
  end

  assign Busy        = (state == RUN) || (state == SIGN);
  assign Ready       = (state == DONE);
  assign Product_out = product;

endmodule

`default_nettype wire
